// File: rtl/sccb_master.sv
// SCCB master: turns one register write/read request into SIOC/SIOD waveforms.
// Optional SCCB_ACK_CHECK_EN samples the don't-care bits and flags a 1 on o_nack.
`timescale 1ns/1ps
module sccb_master #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int SIOC_FREQ = 100_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_id,
    input  logic [7:0] i_sub_addr,
    input  logic [7:0] i_wr_data,
    output logic [7:0] o_rd_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack,
    output logic       o_sioc,
    output logic       o_siod_out,
    output logic       o_siod_oe,
    input  logic       i_siod_in
);
    localparam int QTR = CLK_FREQ / (SIOC_FREQ * 4);
    localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_XBIT, S_STOP, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic          ph2_q, ph2_d;
    logic          rw_q, rw_d;
    logic [6:0]    id_q, id_d;
    logic [7:0]    sub_q, sub_d;
    logic [7:0]    wd_q, wd_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          done_q, done_d;

    logic       tick, slot_end, sample, rd_byte, last_byte;
    logic [7:0] cur_byte;

`ifdef SCCB_ACK_CHECK_EN
    logic nack_q, nack_d;
`endif

    always_comb begin
        tick      = (qcnt_q == QW'(QTR - 1));
        slot_end  = tick && (qtr_q == 2'd3);
        sample    = (qcnt_q == '0) && (qtr_q == 2'd2);
        // byte 1 of the second read phase is the one the slave drives
        rd_byte   = ph2_q && (byte_q == 2'd1);
        last_byte = rw_q ? (byte_q == 2'd1) : (byte_q == 2'd2);
        case (byte_q)
            2'd0:    cur_byte = {id_q, ph2_q};
            2'd1:    cur_byte = sub_q;
            default: cur_byte = wd_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        qcnt_d    = tick ? '0 : qcnt_q + 1'b1;
        qtr_d     = tick ? qtr_q + 2'd1 : qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        ph2_d     = ph2_q;
        rw_d      = rw_q;
        id_d      = id_q;
        sub_d     = sub_q;
        wd_d      = wd_q;
        shift_d   = shift_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
`ifdef SCCB_ACK_CHECK_EN
        nack_d    = nack_q;
`endif
        case (state_q)
            S_IDLE: begin
                qcnt_d = '0;
                qtr_d  = 2'd0;
                if (i_start) begin
                    state_d = S_START;
                    byte_d  = 2'd0;
                    ph2_d   = 1'b0;
                    rw_d    = i_rw;
                    id_d    = i_id;
                    sub_d   = i_sub_addr;
                    wd_d    = i_wr_data;
`ifdef SCCB_ACK_CHECK_EN
                    nack_d  = 1'b0;
`endif
                end
            end
            S_START: begin
                if (slot_end) begin
                    state_d = S_BYTE;
                    bit_d   = 3'd7;
                end
            end
            S_BYTE: begin
                if (sample && rd_byte) shift_d = {shift_q[6:0], i_siod_in};
                if (slot_end) begin
                    if (bit_q == 3'd0) state_d = S_XBIT;
                    else               bit_d   = bit_q - 3'd1;
                end
            end
            S_XBIT: begin
`ifdef SCCB_ACK_CHECK_EN
                if (sample && !rd_byte && i_siod_in) nack_d = 1'b1;
`endif
                if (slot_end) begin
                    if (last_byte) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_BYTE;
                        byte_d  = byte_q + 2'd1;
                        bit_d   = 3'd7;
                    end
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    if (rw_q && !ph2_q) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        if (rw_q) rd_data_d = shift_q;
                    end
                end
            end
            S_GAP: begin
                if (slot_end) begin
                    state_d = S_START;
                    ph2_d   = 1'b1;
                    byte_d  = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd7;
            byte_q    <= 2'd0;
            ph2_q     <= 1'b0;
            rw_q      <= 1'b0;
            id_q      <= 7'd0;
            sub_q     <= 8'd0;
            wd_q      <= 8'd0;
            shift_q   <= 8'd0;
            rd_data_q <= 8'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            ph2_q     <= ph2_d;
            rw_q      <= rw_d;
            id_q      <= id_d;
            sub_q     <= sub_d;
            wd_q      <= wd_d;
            shift_q   <= shift_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
        end
    end

`ifdef SCCB_ACK_CHECK_EN
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) nack_q <= 1'b0;
        else        nack_q <= nack_d;
    end
    assign o_nack = nack_q;
`else
    assign o_nack = 1'b0;
`endif

    // Bus pins decode straight from state so reset idles them without waiting for a clock
    always_comb begin
        o_sioc     = 1'b1;
        o_siod_out = 1'b1;
        o_siod_oe  = 1'b1;
        case (state_q)
            S_START: o_siod_out = (qtr_q < 2'd2);
            S_BYTE: begin
                o_sioc     = qtr_q[1];
                o_siod_out = cur_byte[bit_q];
                o_siod_oe  = !rd_byte;
            end
            S_XBIT: begin
                o_sioc    = qtr_q[1];
                o_siod_oe = rd_byte;
            end
            S_STOP: begin
                o_sioc     = (qtr_q != 2'd0);
                o_siod_out = qtr_q[1];
            end
            default: ;
        endcase
    end

    assign o_busy    = (state_q != S_IDLE);
    assign o_done    = done_q;
    assign o_rd_data = rd_data_q;
endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: bus-decoding slave model plus a scoreboard checked on o_done.
`timescale 1ns/1ps
module tb_sccb_master;
    localparam int CLK_FREQ  = 4_000_000;
    localparam int SIOC_FREQ = 100_000;
    localparam int QTR       = CLK_FREQ / (SIOC_FREQ * 4);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] id = 7'd0;
    logic [7:0] sub = 8'd0;
    logic [7:0] wd = 8'd0;
    logic [7:0] rd_data;
    logic       busy, done, nack, sioc, siod_out, siod_oe;
    logic       slv_drv = 1'b1;

    sccb_master #(.CLK_FREQ(CLK_FREQ), .SIOC_FREQ(SIOC_FREQ)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_rw(rw), .i_id(id),
        .i_sub_addr(sub), .i_wr_data(wd), .o_rd_data(rd_data), .o_busy(busy),
        .o_done(done), .o_nack(nack), .o_sioc(sioc), .o_siod_out(siod_out),
        .o_siod_oe(siod_oe), .i_siod_in(slv_drv)
    );

    always #125 clk = ~clk;

    typedef struct {
        logic [7:0]  rd;
        logic        nack;
        int          cycles;
        logic [35:0] vec;
        int          nbytes;
        int          starts;
        int          stops;
    } exp_t;
    exp_t expq[$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // slave / bus observer state
    logic [7:0]  slv_rd = 8'h00;
    logic        slv_ack = 1'b0;
    wire         bus = siod_oe ? siod_out : slv_drv;
    logic        prev_sioc = 1'b1, prev_bus = 1'b1, last_done = 1'b0, reading = 1'b0;
    logic [8:0]  cur9 = '0;
    logic [35:0] obs_vec = '0;
    int          bitcnt = 0, obs_n = 0, n_start = 0, n_stop = 0, busy_cnt = 0;
    logic [7:0]  model_rd = 8'h00;
    exp_t        e;

    task automatic clear_obs();
        obs_vec = '0; obs_n = 0; n_start = 0; n_stop = 0; busy_cnt = 0; bitcnt = 0;
        reading = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sioc && prev_sioc && prev_bus && !bus) begin
            n_start++; bitcnt = 0; reading = 1'b0;
        end else if (sioc && prev_sioc && !prev_bus && bus) begin
            n_stop++;
        end else if (sioc && !prev_sioc) begin
            cur9 = {cur9[7:0], bus};
            bitcnt++;
            if (bitcnt == 8) reading = bus;
            if (bitcnt % 9 == 0) begin
                obs_vec = {obs_vec[26:0], cur9};
                obs_n++;
            end
        end else if (!sioc && prev_sioc) begin
            slv_drv = (reading && bitcnt >= 9 && bitcnt <= 16) ? slv_rd[16-bitcnt] : slv_ack;
        end
        prev_sioc = sioc;
        prev_bus  = bus;
        if (busy) busy_cnt++;
        if (last_done) check("done_one_cycle", done, 1'b0);
        if (done) begin
            if (expq.size() == 0) begin
                check("unexpected_done", 1'b1, 1'b0);
            end else begin
                e = expq.pop_front();
                check("busy_at_done", busy, 1'b0);
                check("rd_data", rd_data, e.rd);
                check("nack", nack, e.nack);
                check("busy_cycles", busy_cnt, e.cycles);
                check("byte_count", obs_n, e.nbytes);
                check("bus_bits", obs_vec, e.vec);
                check("start_count", n_start, e.starts);
                check("stop_count", n_stop, e.stops);
            end
            clear_obs();
        end
        last_done = done;
    end

    // caller is at a negedge with busy low
    task automatic issue(input bit r, input logic [6:0] i, input logic [7:0] s,
                         input logic [7:0] w, input logic [7:0] rdv, input bit ack);
        exp_t x;
        x.vec = '0;
        x.vec = {x.vec[26:0], i, 1'b0, ack};
        x.vec = {x.vec[26:0], s, ack};
        if (r) begin
            x.vec = {x.vec[26:0], i, 1'b1, ack};
            x.vec = {x.vec[26:0], rdv, 1'b1};
            model_rd = rdv;
        end else begin
            x.vec = {x.vec[26:0], w, ack};
        end
        x.rd     = model_rd;
        x.nbytes = r ? 4 : 3;
        x.starts = r ? 2 : 1;
        x.stops  = r ? 2 : 1;
        x.cycles = (r ? 164 : 116) * QTR;
`ifdef SCCB_ACK_CHECK_EN
        x.nack = ack;
`else
        x.nack = 1'b0;
`endif
        expq.push_back(x);
        slv_rd = rdv; slv_ack = ack;
        rw = r; id = i; sub = s; wd = w; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done) break;
        end
        if (n == 3000) check("done_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (!busy && !done) break;
        end
        if (n == 3000) check("idle_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // 40 cycles = 10 us at 4 MHz
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("idle_pins", {sioc, siod_out, siod_oe, busy}, 4'b1110);
        end
        check("reset_misc", {done, nack, rd_data}, 10'd0);

        @(negedge clk); issue(1'b0, 7'h3C, 8'h12, 8'hA5, 8'h00, 1'b0); wait_idle();
        @(negedge clk); issue(1'b1, 7'h3C, 8'h12, 8'h00, 8'hA5, 1'b0); wait_idle();
        @(negedge clk); issue(1'b0, 7'h21, 8'h80, 8'h0F, 8'h00, 1'b1); wait_idle();

        // start pulse mid-write is ignored, then back-to-back on the done cycle
        @(negedge clk); issue(1'b0, 7'h55, 8'h3A, 8'hC3, 8'h00, 1'b0);
        repeat (300) @(negedge clk);
        rw = 1'b1; id = 7'h7F; sub = 8'hFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done();
        issue(1'b1, 7'h42, 8'h0A, 8'h00, 8'h5C, 1'b1);
        wait_idle();

        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            issue(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), 1'($urandom_range(0, 1)));
            wait_idle();
        end

        // reset during bit 5 of the sub-address byte
        @(negedge clk); issue(1'b0, 7'h3C, 8'h12, 8'hA5, 8'h00, 1'b0);
        repeat (50 * QTR - 1) @(posedge clk);
        #50 rst_n = 1'b0;
        #1 check("reset_abort_pins", {sioc, siod_out, siod_oe, busy, done}, 5'b11100);
        expq.delete();
        model_rd = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); clear_obs();
        check("post_reset_rd", rd_data, 8'h00);
        issue(1'b0, 7'h3C, 8'h12, 8'hA5, 8'h00, 1'b0); wait_idle();
        @(negedge clk); issue(1'b1, 7'h1B, 8'h34, 8'h00, 8'h96, 1'b0); wait_idle();

        repeat (5) @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sccb_master.md
Name: sccb_master

Overview:
- SCCB (OV5642 control bus) master that turns single register-access requests into SIOC/SIOD bus waveforms.
- Sits upstream of the camera (or the sccb_slave bench model) and is driven by the camera init sequencer.
- Supports a 3-phase write (ID, sub-address, data) and a 2-phase write followed by a 2-phase read.
- SIOD is split into out / output-enable / in for tri-state pad or bench hookup.

Parameters:
CLK_FREQ, 100_000_000, i_clk frequency in Hz
SIOC_FREQ, 100_000, SIOC frequency in Hz; quarter-period QTR = CLK_FREQ/(SIOC_FREQ*4) clocks (250 by default)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
i_start  in  1  request strobe, accepted only when o_busy=0
i_rw  in  1  0 = write, 1 = read; sampled with i_start
i_id  in  7  7-bit device ID; the R/W bit is appended by the block
i_sub_addr  in  8  register sub-address
i_wr_data  in  8  write data
o_rd_data  out  8  read result, valid when o_done pulses after a read
o_busy  out  1  transaction in progress
o_done  out  1  one-cycle completion pulse
o_nack  out  1  ACK-check result (see Optional Feature)
o_sioc  out  1  SIOC output
o_siod_out  out  1  SIOD drive value
o_siod_oe  out  1  SIOD output enable (1 = master drives)
i_siod_in  in  1  SIOD sampled value

Behaviour:
- Reset (async assert, sync release) values: o_sioc=1, o_siod_out=1, o_siod_oe=1, o_busy=0, o_done=0, o_nack=0, o_rd_data=0. State returns to IDLE.
- Reset mid-transaction aborts immediately; the bus returns to idle-high with no STOP generated.
- Request accept: cycle with i_start=1 and o_busy=0 latches i_rw, i_id, i_sub_addr and i_wr_data.
  - o_busy rises the next cycle.
  - i_start while o_busy=1 is ignored.
- Timing base: a quarter counter counts 0..QTR-1. Each bit slot is 4 quarters:
  - q0: SIOC low; SIOD changes at the start of q0.
  - q1: SIOC low.
  - q2: SIOC high; the master samples i_siod_in on the first cycle of q2.
  - q3: SIOC high.
- States: IDLE, START, BYTE, XBIT, STOP, GAP.
  - START (4q): SIOD=1 with SIOC=1 for q0-q1; SIOD=0 for q2-q3; SIOC falls on exit.
  - BYTE: 8 bit slots, MSB first, bit counter 7..0.
  - XBIT: 9th slot.
    - During write-direction bytes, o_siod_oe=0 (don't-care bit).
    - After read data, the master drives NA=1.
  - STOP (4q): SIOD=0 with SIOC low for q0; SIOC high for q1; SIOD=1 for q2-q3.
  - GAP (4q): bus idle-high between the read's two phases.
- Write: START, {id,0}, X, sub_addr, X, data, X, STOP. Total 116 quarters.
- Read, phase 1: START, {id,0}, X, sub_addr, X, STOP, GAP.
- Read, phase 2: START, {id,1}, X, 8 data bits with o_siod_oe=0 shifted into a shift register, NA=1, STOP. Total 164 quarters.
- A byte-index counter (0..2) selects the source of the next byte. The transfer order is fixed; no sub-address auto-increment.
- Completion:
  - o_done pulses for 1 cycle on the cycle after STOP's last quarter.
  - o_busy falls in that same cycle.
  - o_rd_data updates on that cycle for reads only and otherwise holds its value.
  - o_busy is high for exactly 116*QTR (write) or 164*QTR (read) cycles.
- Back-to-back: i_start may be asserted in the same cycle o_done pulses; it is accepted because o_busy=0.

Optional Feature:
- Macro SCCB_ACK_CHECK_EN.
- When defined:
  - The master samples i_siod_in at q2 of each write-direction XBIT (the ID bytes and sub_addr/data).
  - If any sampled value is 1, o_nack is set for the transaction.
  - The transaction still completes fully (SCCB ignores ACK).
  - o_nack is cleared on request accept and valid with o_done.
- When undefined: o_nack is tied to 0 and no XBIT sampling logic exists.

Test Plan:
- Reset then idle: no stimulus -> o_sioc=1, o_siod_out=1, o_siod_oe=1, o_busy=0 held for 10 us.
- Write id=0x3C, sub=0x12, data=0xA5 into the sccb_slave model -> slave returns to IDLE with wr_data=0xA5; o_busy=1 for exactly 29000 cycles, then a 1-cycle o_done.
- Read id=0x3C, sub=0x12 with the slave preloaded with 0xA5 -> two START and two STOP conditions; o_rd_data=0xA5 at o_done; o_busy lasted 41000 cycles.
- i_start pulsed mid-write, then a new request on the o_done cycle -> mid-write pulse ignored; second transaction begins immediately; waveform unchanged.
- i_rst asserted at bit 5 of the sub-address byte -> outputs go idle asynchronously within the same cycle; a fresh write after release completes normally.
- SCCB_ACK_CHECK_EN defined, with i_siod_in held at 1 during a write -> o_nack=1 at o_done; with i_siod_in=0 at the XBITs, o_nack=0.
